// File: rtl/dl166_pkg.sv
// Shared constants and state encodings for the program loader and its UART receiver.
package dl166_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         PROG_DEPTH = 16;
  localparam int         ADR_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid/framing-error strobes.
// Strobes fire on the mid-stop-bit sample; there is no backpressure, the consumer must take the byte then.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);
  import dl166_pkg::*;

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        tick_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // A line already back high at mid start bit is a glitch, not a character.
        if (tick_q == HALF_LAST) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tick_q == BIT_LAST) begin
          tick_d  = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick_q == BIT_LAST) begin
          tick_d   = '0;
          rx_valid = sync2_q;
          rx_ferr  = !sync2_q;
          state_d  = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/prog_loader.sv
// Program store for the 4-bit core: 16x8 RAM read combinationally, filled from a UART frame
// (sync, 16 data, checksum); the core is held in reset until a frame commits. No backpressure.
module prog_loader
  import dl166_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 20 * 434
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  input  logic [ADR_W-1:0] adr,
  output logic [7:0]       dout,
  output logic             cpu_reset_n,
  output logic             loaded,
  output logic             err
);

  localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [ADR_W-1:0] CNT_LAST = ADR_W'(PROG_DEPTH - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .rxd     (rxd),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr)
  );

  ld_state_e        state_q, state_d;
  logic [ADR_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             crn_q, crn_d;
  logic             loaded_q, loaded_d;
  logic             err_q, err_d;
  logic             mem_we;
  logic [7:0]       mem_q [PROG_DEPTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    tmo_d    = '0;
    crn_d    = crn_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          crn_d   = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD, CHECK: begin
        tmo_d = tmo_q + 1'b1;
        // A byte arriving on the timeout cycle still counts.
        if (rx_valid) begin
          tmo_d = '0;
          if (state_q == LOAD) begin
            mem_we = 1'b1;
            sum_d  = sum_q + rx_byte;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = CHECK;
          end else begin
            state_d = IDLE;
            if (rx_byte == sum_q) begin
              crn_d    = 1'b1;
              loaded_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (rx_ferr || tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sum_q    <= '0;
      tmo_q    <= '0;
      crn_q    <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < PROG_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      tmo_q    <= tmo_d;
      crn_q    <= crn_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      if (mem_we) mem_q[cnt_q] <= rx_byte;
    end
  end

  assign dout        = mem_q[adr];
  assign cpu_reset_n = crn_q;
  assign loaded      = loaded_q;
  assign err         = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream program-store stage for the 4-bit `cpu` core. It holds a 16×8 writable program RAM and serves the instruction byte asynchronously on `dout` for the core's 4-bit `adr`. The RAM is filled from a UART byte stream framed as sync, 16 data bytes, then checksum. While a load is in progress, or until the first valid load, it holds the core in reset through `cpu_reset_n`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clocks per UART bit; must be ≥ 4.
- `TIMEOUT_CLKS`, default 20×434: maximum idle gap between bytes inside a frame before the frame is aborted.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-low.
- `rxd`, in, 1: asynchronous UART line, idle high, 8N1, LSB first.
- `adr`, in, 4: instruction address from the core.
- `dout`, out, 8: instruction byte `mem[adr]`, combinational.
- `cpu_reset_n`, out, 1: drives the core's `reset` input; 0 holds the core in reset.
- `loaded`, out, 1: 1 once at least one frame has committed since reset.
- `err`, out, 1: sticky error from the last frame (framing, timeout or checksum).

## Operation
- Reset (`reset`=0 at a clk edge): all 16 RAM bytes become 0x00; FSM goes to IDLE.
- Reset output values: `cpu_reset_n`=0, `loaded`=0, `err`=0, `dout`=0x00.
- Reset mid-frame: the frame is discarded, with the same reset values as above.
- RX front end: `rxd` passes through a 2-flop synchronizer.
- Start-bit detection: a falling edge starts the receiver. It samples at `CLKS_PER_BIT/2`; if the line is high there, it is a glitch and the receiver returns to idle.
- Data bits: 8 bits sampled every `CLKS_PER_BIT`, LSB first.
- Stop bit: sampled once more. 1 gives a 1-cycle `rx_valid` with the byte; 0 gives a 1-cycle `rx_ferr` and the byte is dropped.
- Loader FSM:
  - IDLE: bytes other than 0xA5 are ignored. 0xA5 sets `cpu_reset_n`=0 and `err`=0, clears the byte counter `cnt` to 0 and the checksum `sum` to 0, then goes to LOAD.
  - LOAD: each byte is written to `mem[cnt]`, `sum` += byte (8-bit, wraps mod 256), `cnt`++. After the byte with `cnt`=15 the FSM goes to CHECK. A data byte equal to 0xA5 is data, not a resync.
  - CHECK: the next byte is compared with `sum`.
    - Equal: `cpu_reset_n`=1, `loaded`=1, go to IDLE.
    - Not equal: `err`=1, `cpu_reset_n` stays 0, go to IDLE.
- Abort in LOAD/CHECK: `rx_ferr`, or a gap of ≥ `TIMEOUT_CLKS` clocks since the last `rx_valid`, sets `err`=1 and returns to IDLE. `cpu_reset_n` stays 0 and RAM keeps any partial writes.
- Abort in IDLE: `rx_ferr` is ignored; `err` is not set.
- `dout`: `mem[adr]` at all times, including during a load (the core is in reset then).
- A new sync byte in IDLE after a committed load restarts loading: the core is re-held in reset and `loaded` stays 1.

## Timing
- `rx_valid` fires on the cycle of the mid-stop-bit sample, about 9.5 bit times after the start edge plus 2 synchronizer cycles.
- Sync accept: `cpu_reset_n` falls on the clk edge after `rx_valid` for 0xA5.
- RAM write: `mem[cnt]` updates on the clk edge after `rx_valid`. `dout` reflects the new value in the same cycle if `adr`=`cnt`.
- Commit: `cpu_reset_n` and `loaded` rise on the clk edge after `rx_valid` of a matching checksum. The core executes `mem[0]` on the following edge.
- Timeout counter: cleared on every `rx_valid` and on entry to LOAD; counts only in LOAD/CHECK. Abort happens on the edge where the count reaches `TIMEOUT_CLKS`.
- Simultaneous timeout and `rx_valid` on the same cycle: `rx_valid` wins.
- `reset` has priority over all other events.

## Structure
- Shared package `dl166_pkg`:
  - `SYNC_BYTE` = 8'hA5.
  - `PROG_DEPTH` = 16.
  - `ADR_W` = 4.
  - Loader state enum {IDLE, LOAD, CHECK}.
- Sub-module `uart_rx`: synchronizer, bit timer and shift register, with outputs `rx_byte[7:0]`, `rx_valid` and `rx_ferr`; parameter `CLKS_PER_BIT`.
- `prog_loader` contains the FSM, counter, checksum, timeout counter and RAM.

## Test plan
Run with `CLKS_PER_BIT`=8 and `TIMEOUT_CLKS`=200.
1. Reset then idle:
   - Stimulus: reset, leave `rxd` high.
   - Required: `cpu_reset_n`=0, `loaded`=0, `err`=0, `dout`=0x00 for every `adr`.
2. Good frame:
   - Stimulus: send A5, bytes 0x00..0x0F, then checksum 0x78.
   - Required: `mem[i]`=i; `cpu_reset_n`=1 and `loaded`=1 one cycle after the final `rx_valid`; `adr`=9 gives `dout`=0x09.
3. Bad checksum:
   - Stimulus: same frame with checksum 0x79.
   - Required: `err`=1, `cpu_reset_n`=0, `loaded` unchanged.
   - Follow-up: send a good frame; `err` clears at its sync byte.
4. Stop-bit errors:
   - Stimulus: framing error (stop bit 0) on data byte 5.
   - Required: `err`=1, FSM in IDLE; the following stray bytes (e.g. 0x3C) are ignored.
   - Stimulus: a 3-clock low glitch on `rxd`.
   - Required: no byte received.
5. Timeout:
   - Stimulus: A5 plus 4 bytes, then silence for 200 clocks.
   - Required: `err`=1, FSM in IDLE.
   - Stimulus: data byte 0xA5 at position 3 of a good frame.
   - Required: stored as data; frame still commits.
6. Reset mid-frame:
   - Stimulus: assert `reset` after data byte 7.
   - Required: RAM all 0x00, all outputs at reset values; a subsequent good frame commits.
